// File: rtl/btn_pkg.sv
// Shared defaults and helpers for the pushbutton front end.
package btn_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 1000000;
  localparam int unsigned SYNC_DEFAULT     = 2;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchronises one raw button and only lets its level change after it has been
// seen at the new value for DEBOUNCE_CYCLES consecutive cycles.
module debounce_filter
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sampled;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;

  assign sampled = sync_q[SYNC_STAGES-1];
  assign o_level = level_q;

  // Any sample agreeing with the current level restarts qualification.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sampled != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sampled;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch button front end: debounced reset level, one-cycle pause pulse and
// a pause state that toggles per press unless adjust mode is selected.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnP,
  input  logic btnR,
  input  logic adj,
  output logic o_rst,
  output logic o_pause,
  output logic o_pause_state
);

  logic                   p_level, r_level;
  logic                   p_level_q;
  logic [SYNC_STAGES-1:0] adj_sync_q;
  logic                   adj_s;
  logic                   pause_d;
  logic                   pause_q;
  logic                   pause_state_d, pause_state_q;
  logic                   rst_q;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_deb_p (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (btnP),
    .o_level(p_level)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_deb_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (btnR),
    .o_level(r_level)
  );

  assign adj_s = adj_sync_q[SYNC_STAGES-1];

  // Reset button held down masks any pause edge arriving with it.
  assign pause_d = p_level & ~p_level_q & ~r_level;

  always_comb begin
    pause_state_d = pause_state_q;
    if (r_level) begin
      pause_state_d = 1'b0;
    end else if (pause_d && !adj_s) begin
      pause_state_d = ~pause_state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adj_sync_q    <= '0;
      p_level_q     <= 1'b0;
      pause_q       <= 1'b0;
      pause_state_q <= 1'b0;
      rst_q         <= 1'b1;
    end else begin
      adj_sync_q    <= {adj_sync_q[SYNC_STAGES-2:0], adj};
      p_level_q     <= p_level;
      pause_q       <= pause_d;
      pause_state_q <= pause_state_d;
      rst_q         <= r_level;
    end
  end

  assign o_rst         = rst_q;
  assign o_pause       = pause_q;
  assign o_pause_state = pause_state_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed press scenarios plus random buttons
// compared every cycle against a history-window reference model.
module tb_button_conditioner;

  localparam int D   = 4;
  localparam int S   = 2;
  localparam int LAT = S + D + 1;

  logic clk = 1'b0;
  logic rst_n, btnP, btnR, adj;
  logic o_rst, o_pause, o_pause_state;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btnP         (btnP),
    .btnR         (btnR),
    .adj          (adj),
    .o_rst        (o_rst),
    .o_pause      (o_pause),
    .o_pause_state(o_pause_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: inputs reach the filter S cycles late; a level flips once
  // the last D samples all disagree with it.
  bit pq[$], rq[$], aq[$];
  bit ph[$], rh[$];
  bit p_st, r_st, p_st_q;
  bit m_rst, m_pause, m_state;

  function automatic bit all_differ(input bit h[$], input bit st);
    if (h.size() < D) return 1'b0;
    for (int i = 0; i < D; i++) begin
      if (h[h.size() - 1 - i] == st) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit a_s, ps, rs, pulse;
    if (!rst_n) begin
      pq = {}; rq = {}; aq = {};
      for (int i = 0; i < S; i++) begin
        pq.push_back(1'b0); rq.push_back(1'b0); aq.push_back(1'b0);
      end
      ph.push_back(1'b0); rh.push_back(1'b0);
      p_st = 1'b0; r_st = 1'b0; p_st_q = 1'b0;
      m_rst = 1'b1; m_pause = 1'b0; m_state = 1'b0;
    end else begin
      a_s = aq[0]; ps = pq[0]; rs = rq[0];
      pulse   = p_st && !p_st_q && !r_st;
      m_rst   = r_st;
      m_pause = pulse;
      if (r_st) m_state = 1'b0;
      else if (pulse && !a_s) m_state = !m_state;
      p_st_q = p_st;
      void'(pq.pop_front()); pq.push_back(btnP);
      void'(rq.pop_front()); rq.push_back(btnR);
      void'(aq.pop_front()); aq.push_back(adj);
      ph.push_back(ps);
      rh.push_back(rs);
      if (all_differ(ph, p_st)) p_st = !p_st;
      if (all_differ(rh, r_st)) r_st = !r_st;
    end
    while (ph.size() > D) void'(ph.pop_front());
    while (rh.size() > D) void'(rh.pop_front());
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("model_o_rst", o_rst, m_rst);
    check("model_o_pause", o_pause, m_pause);
    check("model_o_pause_state", o_pause_state, m_state);
  endtask

  task automatic press(input int hold, output int first, output int np);
    btnP  = 1'b1;
    first = -1;
    np    = 0;
    for (int c = 1; c <= hold; c++) begin
      tick();
      if (o_pause) begin
        np++;
        if (first < 0) first = c;
      end
    end
    btnP = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (o_pause) np++;
    end
  endtask

  typedef struct {
    bit adj;
    bit exp_state;
  } press_rec_t;

  press_rec_t tbl[5];

  initial begin
    int first, np, p_left, r_left;
    bit bounce[10];

    tbl[0] = '{adj: 1'b0, exp_state: 1'b1};
    tbl[1] = '{adj: 1'b0, exp_state: 1'b0};
    tbl[2] = '{adj: 1'b1, exp_state: 1'b0};
    tbl[3] = '{adj: 1'b0, exp_state: 1'b1};
    tbl[4] = '{adj: 1'b1, exp_state: 1'b1};
    bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

    rst_n = 1'b0; btnP = 1'b0; btnR = 1'b0; adj = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_o_rst", o_rst, 1);
      check("reset_o_pause", o_pause, 0);
      check("reset_o_pause_state", o_pause_state, 0);
    end
    rst_n = 1'b1;
    tick();
    check("release_o_rst", o_rst, 0);
    repeat (4) tick();

    for (int i = 0; i < 5; i++) begin
      adj = tbl[i].adj;
      repeat (3) tick();
      press(20, first, np);
      check("press_pulse_cycle", first, LAT);
      check("press_pulse_count", np, 1);
      check("press_state", o_pause_state, tbl[i].exp_state);
    end
    adj = 1'b0;
    repeat (3) tick();

    // Bounce: last 0->1 lands at index 5, so the pulse is due LAT edges later.
    first = -1; np = 0;
    for (int c = 1; c <= 25; c++) begin
      btnP = (c <= 10) ? bounce[c-1] : 1'b1;
      tick();
      if (o_pause) begin
        np++;
        if (first < 0) first = c;
      end
    end
    btnP = 1'b0;
    repeat (12) tick();
    check("bounce_pulse_cycle", first, 5 + LAT);
    check("bounce_pulse_count", np, 1);
    check("bounce_state", o_pause_state, 0);

    // Bring pause state to 1, then press reset and pause together.
    press(12, first, np);
    check("pre_prio_state", o_pause_state, 1);
    btnR = 1'b1; btnP = 1'b1;
    first = -1; np = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (o_rst && first < 0) first = c;
      if (o_pause) np++;
    end
    check("prio_rst_cycle", first, LAT);
    check("prio_state", o_pause_state, 0);
    btnR = 1'b0; btnP = 1'b0;
    first = -1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (!o_rst && first < 0) first = c;
      if (o_pause) np++;
    end
    check("prio_rst_release_cycle", first, LAT);
    check("prio_pulse_count", np, 0);

    // Mid-debounce reset: the held button must fully re-qualify.
    btnP = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("mid_reset_o_rst", o_rst, 1);
    rst_n = 1'b1;
    first = -1; np = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (o_pause) begin
        np++;
        if (first < 0) first = c;
      end
    end
    check("mid_reset_pulse_cycle", first, LAT);
    check("mid_reset_pulse_count", np, 1);
    btnP = 1'b0;
    repeat (12) tick();

    p_left = 0; r_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (p_left == 0) begin
        btnP   = 1'($urandom_range(0, 1));
        p_left = int'($urandom_range(1, 9));
      end
      if (r_left == 0) begin
        btnR   = ($urandom_range(0, 3) == 0);
        r_left = int'($urandom_range(1, 12));
      end
      p_left--;
      r_left--;
      if ($urandom_range(0, 39) == 0) adj = !adj;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
